// File: rtl/scr1_imem_arb2_pkg.sv
// rtl/scr1_imem_arb2_pkg.sv - shared memory-interface types and widths for the IMEM arbiter
package scr1_imem_arb2_pkg;

    localparam int SCR1_IMEM_AWIDTH = 32;
    localparam int SCR1_IMEM_DWIDTH = 32;

    typedef enum logic [1:0] {
        SCR1_MEM_CMD_RD    = 2'b00,
        SCR1_MEM_CMD_WR    = 2'b01,
        SCR1_MEM_CMD_ERROR = 2'b11
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_imem_arb2_if.sv
// rtl/scr1_imem_arb2_if.sv - req/ack address phase plus resp/rdata data phase bundle
interface scr1_imem_arb2_if;
    import scr1_imem_arb2_pkg::*;

    logic                          req;
    logic                          req_ack;
    type_scr1_mem_cmd_e            cmd;
    logic [SCR1_IMEM_AWIDTH-1:0]   addr;
    logic [SCR1_IMEM_DWIDTH-1:0]   rdata;
    type_scr1_mem_resp_e           resp;

    // The side that issues requests
    modport master (
        output req, cmd, addr,
        input  req_ack, rdata, resp
    );

    // The side that accepts requests and returns responses
    modport slave (
        input  req, cmd, addr,
        output req_ack, rdata, resp
    );

endinterface

// File: rtl/scr1_arb2_rr.sv
// rtl/scr1_arb2_rr.sv - two-way grant with address-phase lock and round-robin pointer
module scr1_arb2_rr #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       issue_i,
    input  logic       accept_i,
    output logic       grant_o
);

    logic lock_q, lock_d;
    logic lock_id_q, lock_id_d;
    logic last_grant_q, last_grant_d;
    logic lock_hold;

    // The lock only pins the grant while its master keeps asking; a dropped
    // request reopens arbitration at once so a stale address is never issued.
    assign lock_hold = lock_q & req_i[lock_id_q];

    // Grant selection: lock, then single requester, then tie-break
    always_comb begin
        grant_o = 1'b0;
        if (lock_hold) begin
            grant_o = lock_id_q;
        end else if (req_i == 2'b01) begin
            grant_o = 1'b0;
        end else if (req_i == 2'b10) begin
            grant_o = 1'b1;
        end else if (req_i == 2'b11) begin
            grant_o = RR_EN ? ~last_grant_q : 1'b0;
        end
    end

    // Lock and pointer next state
    always_comb begin
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;
        last_grant_d = last_grant_q;
        if (accept_i) begin
            lock_d       = 1'b0;
            last_grant_d = grant_o;
        end else if (issue_i) begin
            lock_d       = 1'b1;
            lock_id_d    = grant_o;
        end else if (lock_q && !req_i[lock_id_q]) begin
            lock_d       = 1'b0;
        end
    end

    // Lock and pointer registers; pointer resets to m1 so m0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q       <= 1'b0;
            lock_id_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/scr1_imem_arb2.sv
// rtl/scr1_imem_arb2.sv - two-master arbiter for a single-outstanding IMEM read port
module scr1_imem_arb2
    import scr1_imem_arb2_pkg::*;
#(
    parameter bit SCR1_ARB_RR = 1'b1
) (
    input  logic                    rst_n,
    input  logic                    clk,
    scr1_imem_arb2_if.slave         m0,
    scr1_imem_arb2_if.slave         m1,
    scr1_imem_arb2_if.master        mem
);

    typedef enum logic {
        ARB_FSM_ADDR = 1'b0,
        ARB_FSM_DATA = 1'b1
    } type_arb_fsm_e;

    type_arb_fsm_e fsm_q, fsm_d;
    logic          owner_q, owner_d;
    logic          grant;
    logic          any_req;
    logic          slot_free;
    logic          mem_req;
    logic          handshake;

    // A new address phase may start when idle or in the cycle the current
    // transaction completes successfully; an error response costs one bubble.
    assign any_req   = m0.req | m1.req;
    assign slot_free = (fsm_q == ARB_FSM_ADDR) |
                       ((fsm_q == ARB_FSM_DATA) & (mem.resp == SCR1_MEM_RESP_RDY_OK));
    assign mem_req   = slot_free & any_req;
    assign handshake = mem_req & mem.req_ack;

    scr1_arb2_rr #(
        .RR_EN    (SCR1_ARB_RR)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({m1.req, m0.req}),
        .issue_i  (mem_req),
        .accept_i (handshake),
        .grant_o  (grant)
    );

    // Transaction state and owner registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ARB_FSM_ADDR;
            owner_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            owner_q <= owner_d;
        end
    end

    // Next state: enter DATA on every handshake, leave on any final response
    always_comb begin
        fsm_d   = fsm_q;
        owner_d = owner_q;
        if (handshake) begin
            owner_d = grant;
        end
        case (fsm_q)
            ARB_FSM_ADDR: begin
                if (handshake) fsm_d = ARB_FSM_DATA;
            end
            ARB_FSM_DATA: begin
                case (mem.resp)
                    SCR1_MEM_RESP_NOTRDY: fsm_d = ARB_FSM_DATA;
                    SCR1_MEM_RESP_RDY_OK: fsm_d = handshake ? ARB_FSM_DATA : ARB_FSM_ADDR;
                    default:              fsm_d = ARB_FSM_ADDR;
                endcase
            end
            default: fsm_d = ARB_FSM_ADDR;
        endcase
    end

    // Outputs: steer the granted request out and the response back to its owner
    always_comb begin
        mem.req    = mem_req;
        mem.cmd    = any_req ? (grant ? m1.cmd : m0.cmd) : SCR1_MEM_CMD_ERROR;
        mem.addr   = grant ? m1.addr : m0.addr;
        m0.req_ack = handshake & ~grant;
        m1.req_ack = handshake &  grant;
        m0.rdata   = mem.rdata;
        m1.rdata   = mem.rdata;
        m0.resp    = SCR1_MEM_RESP_NOTRDY;
        m1.resp    = SCR1_MEM_RESP_NOTRDY;
        if (fsm_q == ARB_FSM_DATA) begin
            if (owner_q) m1.resp = mem.resp;
            else         m0.resp = mem.resp;
        end
    end

`ifdef SCR1_TRGT_SIMULATION
    // Protocol sanity: one ack at a time, clean request fields, quiet slave when idle
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(m0.req_ack && m1.req_ack));
            if (mem.req) assert (!$isunknown({mem.cmd, mem.addr}));
            if (fsm_q == ARB_FSM_ADDR) assert (mem.resp == SCR1_MEM_RESP_NOTRDY);
        end
    end
`endif

endmodule

// File: tb/tb_scr1_imem_arb2.sv
// tb/tb_scr1_imem_arb2.sv - directed self-checking bench for scr1_imem_arb2
module tb_scr1_imem_arb2;
    import scr1_imem_arb2_pkg::*;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;
    localparam logic [31:0] NR = 32'(SCR1_MEM_RESP_NOTRDY);
    localparam logic [31:0] OK = 32'(SCR1_MEM_RESP_RDY_OK);
    localparam logic [31:0] ER = 32'(SCR1_MEM_RESP_RDY_ER);

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    scr1_imem_arb2_if rr_m0 ();
    scr1_imem_arb2_if rr_m1 ();
    scr1_imem_arb2_if rr_mem ();
    scr1_imem_arb2_if fx_m0 ();
    scr1_imem_arb2_if fx_m1 ();
    scr1_imem_arb2_if fx_mem ();

    scr1_imem_arb2 #(.SCR1_ARB_RR(1'b1)) dut_rr (
        .rst_n (rst_n),
        .clk   (clk),
        .m0    (rr_m0.slave),
        .m1    (rr_m1.slave),
        .mem   (rr_mem.master)
    );

    scr1_imem_arb2 #(.SCR1_ARB_RR(1'b0)) dut_fx (
        .rst_n (rst_n),
        .clk   (clk),
        .m0    (fx_m0.slave),
        .m1    (fx_m1.slave),
        .mem   (fx_mem.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drv_rr(input logic r0, input logic r1, input logic ack,
                          input type_scr1_mem_resp_e resp, input logic [31:0] rdata);
        rr_m0.req     = r0;
        rr_m1.req     = r1;
        rr_mem.req_ack = ack;
        rr_mem.resp   = resp;
        rr_mem.rdata  = rdata;
    endtask

    task automatic drv_fx(input logic r0, input logic r1, input logic ack,
                          input type_scr1_mem_resp_e resp, input logic [31:0] rdata);
        fx_m0.req     = r0;
        fx_m1.req     = r1;
        fx_mem.req_ack = ack;
        fx_mem.resp   = resp;
        fx_mem.rdata  = rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rr_m0.cmd = SCR1_MEM_CMD_RD; rr_m0.addr = A0;
        rr_m1.cmd = SCR1_MEM_CMD_RD; rr_m1.addr = A1;
        fx_m0.cmd = SCR1_MEM_CMD_RD; fx_m0.addr = A0;
        fx_m1.cmd = SCR1_MEM_CMD_RD; fx_m1.addr = A1;
        drv_rr(1'b0, 1'b0, 1'b0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        drv_fx(1'b0, 1'b0, 1'b0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;

        // Reset state with idle inputs
        chk("rst_mem_req", 32'(rr_mem.req), 0);
        chk("rst_m0_ack",  32'(rr_m0.req_ack), 0);
        chk("rst_m1_ack",  32'(rr_m1.req_ack), 0);
        chk("rst_m0_resp", 32'(rr_m0.resp), NR);
        chk("rst_m1_resp", 32'(rr_m1.resp), NR);
        chk("rst_mem_cmd", 32'(rr_mem.cmd), 32'(SCR1_MEM_CMD_ERROR));
        tick();

        // Single master read of 0x100 with immediate ack
        rr_m0.addr = 32'h0000_0100;
        drv_rr(1'b1, 1'b0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        #2;
        chk("single_mem_req",  32'(rr_mem.req), 1);
        chk("single_mem_addr", rr_mem.addr, 32'h0000_0100);
        chk("single_mem_cmd",  32'(rr_mem.cmd), 32'(SCR1_MEM_CMD_RD));
        chk("single_m0_ack",   32'(rr_m0.req_ack), 1);
        chk("single_m1_ack",   32'(rr_m1.req_ack), 0);
        tick();
        drv_rr(1'b0, 1'b0, 1'b1, SCR1_MEM_RESP_RDY_OK, 32'hDEAD_BEEF);
        #2;
        chk("single_m0_resp",  32'(rr_m0.resp), OK);
        chk("single_m0_rdata", rr_m0.rdata, 32'hDEAD_BEEF);
        chk("single_m1_resp",  32'(rr_m1.resp), NR);
        chk("single_idle_req", 32'(rr_mem.req), 0);
        tick();
        rr_m0.addr = A0;
        drv_rr(1'b0, 1'b0, 1'b0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        #2;
        chk("single_after_resp", 32'(rr_m0.resp), NR);

        // Fresh reset so the round-robin run starts from the reset pointer
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();

        // Both request every cycle, zero-wait slave: alternate m0,m1,...
        for (int k = 0; k < 8; k++) begin
            drv_rr(1'b1, 1'b1, 1'b1, (k == 0) ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK, 32'(k));
            #2;
            chk($sformatf("rr_m0_ack_%0d", k), 32'(rr_m0.req_ack), 32'((k % 2) == 0));
            chk($sformatf("rr_m1_ack_%0d", k), 32'(rr_m1.req_ack), 32'((k % 2) == 1));
            chk($sformatf("rr_addr_%0d", k), rr_mem.addr, ((k % 2) == 0) ? A0 : A1);
            if (k > 0) begin
                chk($sformatf("rr_m0_resp_%0d", k), 32'(rr_m0.resp), (((k - 1) % 2) == 0) ? OK : NR);
                chk($sformatf("rr_m1_resp_%0d", k), 32'(rr_m1.resp), (((k - 1) % 2) == 1) ? OK : NR);
            end
            tick();
        end
        drv_rr(1'b0, 1'b0, 1'b1, SCR1_MEM_RESP_RDY_OK, 32'h7);
        #2;
        chk("rr_drain_m1_resp", 32'(rr_m1.resp), OK);
        chk("rr_drain_mem_req", 32'(rr_mem.req), 0);
        tick();
        drv_rr(1'b0, 1'b0, 1'b0, SCR1_MEM_RESP_NOTRDY, 32'h0);

        // Fixed priority: every tie goes to m0
        for (int k = 0; k < 8; k++) begin
            drv_fx(1'b1, 1'b1, 1'b1, (k == 0) ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK, 32'(k));
            #2;
            chk($sformatf("fx_m0_ack_%0d", k), 32'(fx_m0.req_ack), 1);
            chk($sformatf("fx_m1_ack_%0d", k), 32'(fx_m1.req_ack), 0);
            if (k > 0) chk($sformatf("fx_m0_resp_%0d", k), 32'(fx_m0.resp), OK);
            tick();
        end
        drv_fx(1'b0, 1'b0, 1'b1, SCR1_MEM_RESP_RDY_OK, 32'h7);
        tick();
        drv_fx(1'b0, 1'b0, 1'b0, SCR1_MEM_RESP_NOTRDY, 32'h0);

        // Lock: m1 stalled three cycles, m0 joins in cycle 2 but cannot steal
        drv_rr(1'b0, 1'b1, 1'b0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        #2;
        chk("lock_c1_req",  32'(rr_mem.req), 1);
        chk("lock_c1_addr", rr_mem.addr, A1);
        chk("lock_c1_m1_ack", 32'(rr_m1.req_ack), 0);
        tick();
        for (int c = 2; c <= 3; c++) begin
            drv_rr(1'b1, 1'b1, 1'b0, SCR1_MEM_RESP_NOTRDY, 32'h0);
            #2;
            chk($sformatf("lock_c%0d_addr", c), rr_mem.addr, A1);
            chk($sformatf("lock_c%0d_m0_ack", c), 32'(rr_m0.req_ack), 0);
            tick();
        end
        drv_rr(1'b1, 1'b1, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        #2;
        chk("lock_c4_m1_ack", 32'(rr_m1.req_ack), 1);
        chk("lock_c4_m0_ack", 32'(rr_m0.req_ack), 0);
        tick();
        drv_rr(1'b1, 1'b0, 1'b1, SCR1_MEM_RESP_RDY_OK, 32'h1111_2222);
        #2;
        chk("lock_c5_m1_resp", 32'(rr_m1.resp), OK);
        chk("lock_c5_m0_ack",  32'(rr_m0.req_ack), 1);
        chk("lock_c5_addr",    rr_mem.addr, A0);
        tick();

        // Error response on m0's transaction: m1 waits one bubble cycle
        drv_rr(1'b0, 1'b1, 1'b1, SCR1_MEM_RESP_RDY_ER, 32'h0);
        #2;
        chk("err_m0_resp",  32'(rr_m0.resp), ER);
        chk("err_mem_req",  32'(rr_mem.req), 0);
        chk("err_m1_ack",   32'(rr_m1.req_ack), 0);
        tick();
        drv_rr(1'b0, 1'b1, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        #2;
        chk("err_next_m1_ack", 32'(rr_m1.req_ack), 1);
        chk("err_next_req",    32'(rr_mem.req), 1);
        tick();

        // NOTRDY stall on m1's transaction with m0 waiting
        for (int c = 0; c < 5; c++) begin
            drv_rr(1'b1, 1'b0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
            #2;
            chk($sformatf("stall_m1_resp_%0d", c), 32'(rr_m1.resp), NR);
            chk($sformatf("stall_m0_ack_%0d", c), 32'(rr_m0.req_ack), 0);
            chk($sformatf("stall_req_%0d", c), 32'(rr_mem.req), 0);
            tick();
        end
        drv_rr(1'b1, 1'b0, 1'b1, SCR1_MEM_RESP_RDY_OK, 32'hCAFE_F00D);
        #2;
        chk("stall_end_m1_resp",  32'(rr_m1.resp), OK);
        chk("stall_end_m1_rdata", rr_m1.rdata, 32'hCAFE_F00D);
        chk("stall_end_m0_ack",   32'(rr_m0.req_ack), 1);
        tick();

        // Reset while m0's response is pending; pointer favours m1 until reset
        drv_rr(1'b1, 1'b1, 1'b1, SCR1_MEM_RESP_RDY_OK, 32'h0);
        #1;
        chk("prerst_m0_resp", 32'(rr_m0.resp), OK);
        chk("prerst_m1_ack",  32'(rr_m1.req_ack), 1);
        rst_n = 1'b0;
        #1;
        chk("inrst_m0_resp", 32'(rr_m0.resp), NR);
        chk("inrst_m1_resp", 32'(rr_m1.resp), NR);
        chk("inrst_m0_ack",  32'(rr_m0.req_ack), 1);
        chk("inrst_m1_ack",  32'(rr_m1.req_ack), 0);
        rst_n = 1'b1;
        #1;
        chk("postrst_m0_ack", 32'(rr_m0.req_ack), 1);
        chk("postrst_addr",   rr_mem.addr, A0);
        drv_rr(1'b0, 1'b0, 1'b0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/scr1_imem_arb2.md
# scr1_imem_arb2

Two-master arbiter that shares one instruction-memory-style read port (req/req_ack address phase, resp/rdata data phase, one outstanding transaction) between two requesters, e.g. core IMEM fetch and a debug/DMA fetch path. It sits in front of an IMEM router or a single memory, performs round-robin or fixed-priority arbitration, and steers each response back to the master that owns the transaction.

## Interface
- SCR1_ARB_RR, default 1: 1 = round-robin on simultaneous requests; 0 = fixed priority, m0 wins.
- rst_n  input  1  asynchronous active-low reset
- clk  input  1  clock, all state on posedge
- m0_req / m1_req  input  1  master request
- m0_req_ack / m1_req_ack  output  1  address-phase accept to master
- m0_cmd / m1_cmd  input  type_scr1_mem_cmd_e  command
- m0_addr / m1_addr  input  `SCR1_IMEM_AWIDTH  address
- m0_rdata / m1_rdata  output  `SCR1_IMEM_DWIDTH  read data
- m0_resp / m1_resp  output  type_scr1_mem_resp_e  response
- mem_req  output  1  request to shared port
- mem_req_ack  input  1  accept from shared port
- mem_cmd  output  type_scr1_mem_cmd_e  granted master's command
- mem_addr  output  `SCR1_IMEM_AWIDTH  granted master's address
- mem_rdata  input  `SCR1_IMEM_DWIDTH  read data
- mem_resp  input  type_scr1_mem_resp_e  response

## Operation
- State: fsm {ADDR, DATA}, owner (1 bit), last_grant (1 bit), lock (1 bit), lock_id (1 bit).
- slot_free = (fsm==ADDR) | (fsm==DATA & mem_resp==RDY_OK).
- Arbitration (grant, combinational): lock set -> grant=lock_id; else only one req -> that master; both -> RR: ~last_grant; fixed: m0.
- mem_req = slot_free & (m0_req|m1_req); mem_cmd/mem_addr = granted master's; with no request mem_cmd=ERROR, addr=granted master's (don't-care).
- mX_req_ack = slot_free & mem_req & (grant==X) & mem_req_ack; non-granted ack is 0.
- Handshake (mem_req & mem_req_ack): fsm<=DATA, owner<=grant, last_grant<=grant, lock<=0.
- Lock: mem_req & ~mem_req_ack -> lock<=1, lock_id<=grant; grant frozen until ack. Locked master dropping req -> lock<=0 next cycle, arbitration reopens.
- DATA: mem_resp NOTRDY -> hold. RDY_OK -> new handshake this cycle stays DATA (back-to-back), else ADDR. RDY_ER -> ADDR; no new request issued that cycle (slot_free=0).
- Response routing: m[owner]_resp = mem_resp in DATA; other master and both in ADDR see NOTRDY. mem_rdata broadcast to both rdata outputs; valid only with owner's RDY_OK.
- Reset: fsm=ADDR, owner=0, last_grant=1 (m0 wins first tie), lock=0. Outputs with idle inputs: mem_req=0, both acks 0, both resp NOTRDY.
- Reset mid-transaction: in-flight response discarded; masters restart.

## Timing
- req->mem_req, mem_req_ack->mX_req_ack, mem_resp->mX_resp: combinational, zero added latency.
- Throughput: one transaction per cycle when slave answers RDY_OK next cycle; grant may switch masters in the RDY_OK cycle.
- After RDY_ER: one bubble cycle before next request.
- Minimum ack-to-response latency set by slave (>=1 cycle).
- No combinational path mem_resp->mem_req except through slot_free (documented; slave must not loop req_ack on req combinationally through resp).

## Structure
- Uses type_scr1_mem_cmd_e / type_scr1_mem_resp_e from scr1_memif.svh; fsm enum local to module.
- Optional sub-module scr1_arb2_rr: 2-way grant with lock and last_grant pointer, reusable for DMEM arbiter.
- SCR1_TRGT_SIMULATION assertions: grant one-hot acks, no X on cmd/addr while mem_req, no response in ADDR.

## Test plan
- Single master: m0 reads 0x0000_0100, slave acks immediately, RDY_OK next cycle with 0xDEADBEEF -> m0_resp RDY_OK, m0_rdata 0xDEADBEEF, m1_resp NOTRDY.
- Both request every cycle, SCR1_ARB_RR=1, slave zero-wait -> grants alternate m0,m1,m0,m1 over 8 transactions; with RR=0 -> all 8 to m0.
- Lock: m1 requests alone, slave holds mem_req_ack=0 for 3 cycles, m0 raises req in cycle 2 -> mem_addr stays m1's, m1 acked cycle 4, m0 granted after.
- Error: owner m0 gets RDY_ER while m1 requesting -> m1 not acked that cycle, acked next cycle, fsm ADDR->DATA.
- NOTRDY stall: 5 NOTRDY cycles then RDY_OK -> owner resp NOTRDY throughout, no acks during stall, back-to-back ack in RDY_OK cycle.
- Reset asserted in DATA with response pending -> all outputs return to reset values asynchronously; first post-reset tie goes to m0.
